// File: rtl/approx_err_pkg.sv
// Shared definitions for the approximate-adder error monitor:
// run-control state encoding and datapath width helpers.
package approx_err_pkg;

    // Run-control states of the monitor.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Default operand and counter widths.
    localparam int N_DEF     = 16;
    localparam int CNT_W_DEF = 16;

    // Error distance width: one bit wider than the operands to cover carry-out.
    function automatic int ed_width(input int n);
        return n + 1;
    endfunction

    // Error-distance sum width: wide enough that num_samples maximal EDs never overflow.
    function automatic int sum_width(input int n, input int cnt_w);
        return n + 1 + cnt_w;
    endfunction

endpackage

// File: rtl/err_distance.sv
// Two-stage error-distance pipeline.
// Stage 1 registers the exact sum and the approximate result; stage 2 registers
// the absolute error distance and, when ERR_BIAS_EN is defined, the signed
// difference (apx - exact). Without ERR_BIAS_EN the signed path is tied to 0.
module err_distance
    import approx_err_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [N-1:0]        x,
    input  logic [N-1:0]        y,
    input  logic [N-1:0]        s_apx,
    input  logic                co_apx,
    output logic                out_valid,
    output logic [N:0]          ed,
    output logic signed [N+1:0] diff,
    output logic                busy
);

    logic         v1_q;
    logic [N:0]   exact_q;
    logic [N:0]   apx_q;
    logic         v2_q;
    logic [N:0]   ed_q;
    logic [N:0]   ed_d;

    // Absolute distance between approximate and exact results.
    always_comb begin
        ed_d = '0;
        if (apx_q >= exact_q) ed_d = apx_q - exact_q;
        else                  ed_d = exact_q - apx_q;
    end

    // Stage 1: capture exact sum and approximate result of an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            exact_q <= '0;
            apx_q   <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                exact_q <= {1'b0, x} + {1'b0, y};
                apx_q   <= {co_apx, s_apx};
            end
        end
    end

    // Stage 2: register the error distance alongside its valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q <= 1'b0;
            ed_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) ed_q <= ed_d;
        end
    end

`ifdef ERR_BIAS_EN
    logic signed [N+1:0] diff_q;

    // Stage 2 (bias path): signed apx - exact, both zero-extended by one bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q <= '0;
        end else if (v1_q) begin
            diff_q <= $signed({1'b0, apx_q}) - $signed({1'b0, exact_q});
        end
    end

    assign diff = diff_q;
`else
    assign diff = '0;
`endif

    assign out_valid = v2_q;
    assign ed        = ed_q;
    assign busy      = v1_q | v2_q;

endmodule

// File: rtl/approx_err_monitor.sv
// Error-metric monitor for an approximate adder. Accepts a programmed number of
// (x, y, {co, s}) samples, computes the exact sum internally and accumulates
// sample/error counts, maximum and total error distance. Defining ERR_BIAS_EN
// adds a signed bias accumulator (sum of apx - exact); otherwise ed_bias is 0.
module approx_err_monitor
    import approx_err_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         x,
    input  logic [N-1:0]         y,
    input  logic [N-1:0]         s_apx,
    input  logic                 co_apx,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [N:0]           ed_max,
    output logic [N+CNT_W:0]     ed_sum,
    output logic [N+1+CNT_W:0]   ed_bias
);

    localparam int EW = ed_width(N);
    localparam int SW = sum_width(N, CNT_W);

    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic [CNT_W-1:0]    num_q;
    logic [CNT_W-1:0]    accepted_q;
    logic [CNT_W-1:0]    sample_q;
    logic [CNT_W-1:0]    err_q;
    logic [EW-1:0]       max_q;
    logic [SW-1:0]       sum_q;

    logic                transfer;
    logic                clear;
    logic                pipe_valid;
    logic                pipe_busy;
    logic [EW-1:0]       pipe_ed;
    logic signed [N+1:0] pipe_diff;

    // Ready depends only on registered state so there is no path from in_valid.
    assign in_ready = (state_q == RUN) && (accepted_q < num_q);
    assign transfer = in_valid & in_ready;
    assign clear    = (state_q == IDLE) && start;

    err_distance #(.N(N)) u_ed (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (transfer),
        .x         (x),
        .y         (y),
        .s_apx     (s_apx),
        .co_apx    (co_apx),
        .out_valid (pipe_valid),
        .ed        (pipe_ed),
        .diff      (pipe_diff),
        .busy      (pipe_busy)
    );

    // Run-control FSM with registered busy/done and the accepted-beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            num_q      <= '0;
            accepted_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        num_q      <= num_samples;
                        accepted_q <= '0;
                    end
                end
                RUN: begin
                    if (transfer) accepted_q <= accepted_q + 1'b1;
                    if (accepted_q == num_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state_q <= REPORT;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Statistics accumulators: cleared on an accepted start, updated per ED result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= '0;
            err_q    <= '0;
            max_q    <= '0;
            sum_q    <= '0;
        end else if (clear) begin
            sample_q <= '0;
            err_q    <= '0;
            max_q    <= '0;
            sum_q    <= '0;
        end else if (pipe_valid) begin
            sample_q <= sample_q + 1'b1;
            if (pipe_ed != '0)  err_q <= err_q + 1'b1;
            if (pipe_ed > max_q) max_q <= pipe_ed;
            sum_q <= sum_q + SW'(pipe_ed);
        end
    end

`ifdef ERR_BIAS_EN
    logic signed [N+1+CNT_W:0] bias_q;

    // Signed bias accumulator, sign-extending each per-sample difference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_q <= '0;
        end else if (clear) begin
            bias_q <= '0;
        end else if (pipe_valid) begin
            bias_q <= bias_q + {{CNT_W{pipe_diff[N+1]}}, pipe_diff};
        end
    end

    assign ed_bias = bias_q;
`else
    assign ed_bias = '0;
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_count = sample_q;
    assign err_count    = err_q;
    assign ed_max       = max_q;
    assign ed_sum       = sum_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Self-checking bench for approx_err_monitor: directed runs from the test plan
// followed by randomized runs, all checked against an arithmetic reference model.
module tb_approx_err_monitor;

    localparam int N     = 16;
    localparam int CNT_W = 16;

    logic               clk;
    logic               rst;
    logic               start;
    logic [CNT_W-1:0]   num_samples;
    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       x;
    logic [N-1:0]       y;
    logic [N-1:0]       s_apx;
    logic               co_apx;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   sample_count;
    logic [CNT_W-1:0]   err_count;
    logic [N:0]         ed_max;
    logic [N+CNT_W:0]   ed_sum;
    logic [N+1+CNT_W:0] ed_bias;

    int compared;
    int mismatched;

    logic [15:0] sx [64];
    logic [15:0] sy [64];
    logic [16:0] sa [64];

    approx_err_monitor #(.N(N), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_samples  (num_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x            (x),
        .y            (y),
        .s_apx        (s_apx),
        .co_apx       (co_apx),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .ed_max       (ed_max),
        .ed_sum       (ed_sum),
        .ed_bias      (ed_bias)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_cnt"},   64'(sample_count), 64'd0);
        check({tag, "_err"},   64'(err_count), 64'd0);
        check({tag, "_max"},   64'(ed_max), 64'd0);
        check({tag, "_sum"},   64'(ed_sum), 64'd0);
        check({tag, "_bias"},  64'(ed_bias), 64'd0);
        check({tag, "_ready"}, 64'(in_ready), 64'd0);
    endtask

    // Fill the sample table with random operands and a mix of exact/near/wild results.
    task automatic gen_samples(input int n);
        for (int i = 0; i < n; i++) begin
            int unsigned ex;
            int unsigned ap;
            int unsigned mode;
            sx[i] = 16'($urandom);
            sy[i] = 16'($urandom);
            ex    = 32'(sx[i]) + 32'(sy[i]);
            mode  = $urandom_range(0, 2);
            if (mode == 0)      ap = ex;
            else if (mode == 1) ap = ex + $urandom_range(0, 64) - 32;
            else                ap = $urandom;
            sa[i] = 17'(ap & 32'h1FFFF);
        end
    endtask

    // One complete run: start, feed n samples (optionally with gaps or held valid),
    // optionally pulse a disruptive start mid-run, then check results against the model.
    task automatic run(input string tag, input int n, input bit gaps,
                       input bit hold_valid, input bit restart_mid);
        int idx;
        int cyc;
        bit bad_ready;
        bit timed_out;
        longint m_err, m_max, m_sum, m_bias;

        start       = 1'b1;
        num_samples = CNT_W'(n);
        step();
        start       = 1'b0;
        num_samples = CNT_W'($urandom);
        check({tag, "_busy_run"}, 64'(busy), 64'd1);

        idx       = 0;
        cyc       = 0;
        bad_ready = 1'b0;
        timed_out = 1'b0;
        while (!done) begin
            if (cyc >= 2000) begin
                timed_out = 1'b1;
                break;
            end
            if (hold_valid)  in_valid = 1'b1;
            else             in_valid = (idx < n) && (!gaps || ($urandom_range(0, 3) != 0));
            x      = sx[idx % 64];
            y      = sy[idx % 64];
            s_apx  = sa[idx % 64][15:0];
            co_apx = sa[idx % 64][16];
            if (restart_mid && cyc == 1) begin
                start       = 1'b1;
                num_samples = CNT_W'(n + 3);
            end else begin
                start = 1'b0;
            end
            if (idx >= n && in_ready) bad_ready = 1'b1;
            if (in_valid && in_ready) idx++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check({tag, "_timeout"},   64'(timed_out), 64'd0);
        check({tag, "_transfers"}, 64'(idx), 64'(n));
        check({tag, "_ready_hi"},  64'(bad_ready), 64'd0);
        if (n == 0) check({tag, "_done_cycle"}, 64'(cyc), 64'd2);

        // Reference model: plain arithmetic over the samples that were sent.
        m_err = 0; m_max = 0; m_sum = 0; m_bias = 0;
        for (int i = 0; i < n; i++) begin
            longint ex, ap, d, e;
            ex = longint'(sx[i]) + longint'(sy[i]);
            ap = longint'(sa[i]);
            d  = ap - ex;
            e  = (d < 0) ? -d : d;
            if (e != 0) m_err++;
            if (e > m_max) m_max = e;
            m_sum  += e;
            m_bias += d;
        end
`ifndef ERR_BIAS_EN
        m_bias = 0;
`endif
        check({tag, "_cnt"},  64'(sample_count), 64'(n));
        check({tag, "_err"},  64'(err_count), 64'(m_err));
        check({tag, "_max"},  64'(ed_max), 64'(m_max));
        check({tag, "_sum"},  64'(ed_sum), 64'(m_sum));
        check({tag, "_bias"}, 64'(ed_bias), 64'(m_bias) & 64'h3_FFFF_FFFF);
        step();
        check({tag, "_done_once"}, 64'(done), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_hold_cnt"},  64'(sample_count), 64'(n));
        $display("run %s n=%0d transfers=%0d cycles=%0d", tag, n, idx, cyc);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst         = 1'b1;
        start       = 1'b0;
        num_samples = '0;
        in_valid    = 1'b0;
        x           = '0;
        y           = '0;
        s_apx       = '0;
        co_apx      = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_all_zero("post_reset");

        // All-exact results.
        sx[0] = 16'h0001; sy[0] = 16'h0001; sa[0] = 17'h00002;
        sx[1] = 16'h00FF; sy[1] = 16'h00FF; sa[1] = 17'h001FE;
        sx[2] = 16'h0000; sy[2] = 16'h0000; sa[2] = 17'h00000;
        run("exact3", 3, 1'b0, 1'b0, 1'b0);

        // Extreme error distances, including a carry-out error.
        sx[0] = 16'hFFFF; sy[0] = 16'hFFFF; sa[0] = 17'h1FFFF;
        sx[1] = 16'hFFFF; sy[1] = 16'hFFFF; sa[1] = 17'h0FFFE;
        run("extreme2", 2, 1'b0, 1'b0, 1'b0);
        check("extreme2_max_const", 64'(ed_max), 64'h10000);
        check("extreme2_sum_const", 64'(ed_sum), 64'h10001);
`ifdef ERR_BIAS_EN
        check("extreme2_bias_const", 64'(ed_bias), 64'(-64'sd65535) & 64'h3_FFFF_FFFF);
`endif

        // in_valid held high: exactly two transfers.
        gen_samples(4);
        run("hold2", 2, 1'b0, 1'b1, 1'b0);

        // Zero-length run.
        run("zero", 0, 1'b0, 1'b1, 1'b0);

        // Reset mid-run after one sample has reached the accumulators.
        gen_samples(5);
        start       = 1'b1;
        num_samples = 16'd5;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        x = sx[0]; y = sy[0]; s_apx = sa[0][15:0]; co_apx = sa[0][16];
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check("midrst_pre_cnt", 64'(sample_count), 64'd1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        step();
        rst = 1'b0;
        step();
        check_all_zero("midrst_after");
        gen_samples(1);
        run("after_rst", 1, 1'b0, 1'b0, 1'b0);

        // start during RUN is ignored.
        gen_samples(6);
        run("restart_ign", 4, 1'b0, 1'b0, 1'b1);

        // Randomized runs with random gaps and lengths.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 40);
            gen_samples(n);
            run($sformatf("rand%0d", r), n, 1'b1, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Sequential error-metric monitor sitting on the output side of an approximate adder (HOERAA-style, N-bit operands). For each accepted sample it takes the adder's operands (X, Y) and its result ({Co, S}), computes the exact sum internally and accumulates error statistics over a programmed sample run. It is the response-checking end of the adder stimulus interface and supports hardware characterisation runs without a simulator scoreboard.

## Interface
- N, 16, operand width of the monitored adder
- CNT_W, 16, width of sample counters and num_samples
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run when IDLE
- num_samples  in  CNT_W  samples in the run; latched on accepted start
- in_valid  in  1  sample beat valid
- in_ready  out  1  monitor accepts beat; transfer = in_valid & in_ready
- x, y  in  N  adder operands
- s_apx  in  N  approximate sum
- co_apx  in  1  approximate carry-out
- busy  out  1  high in RUN, DRAIN and REPORT
- done  out  1  one-cycle pulse at end of run
- sample_count  out  CNT_W  samples accumulated this run
- err_count  out  CNT_W  samples with nonzero error distance
- ed_max  out  N+1  maximum error distance
- ed_sum  out  N+1+CNT_W  sum of error distances
- ed_bias  out  N+2+CNT_W  signed sum of (apx − exact); see Configuration

## Operation
- exact = x + y (N+1 bits, zero-extended); apx = {co_apx, s_apx}; ED = |apx − exact| (N+1 bits).
- States: IDLE, RUN, DRAIN, REPORT.
- IDLE: in_ready=0. start=1 → clear all accumulators, latch num_samples, → RUN.
- RUN: in_ready = (accepted < num_samples). When accepted == num_samples (including 0) → DRAIN.
- DRAIN: in_ready=0; when both pipeline stages are empty → REPORT.
- REPORT: done=1 for exactly one cycle → IDLE. Results hold in IDLE until next start.
- start outside IDLE is ignored; num_samples changes outside IDLE are ignored.
- Per sample: sample_count+1; err_count+1 if ED≠0; ed_max = max(ed_max, ED); ed_sum += ED.
- ed_sum cannot overflow by width choice; counters cannot exceed num_samples; no saturation logic.
- Reset (any state, mid-run included): state IDLE, pipeline valids cleared, all outputs 0.

## Timing
- Beat accepted cycle t → stage-1 register (exact, apx) at t+1 → ED register at t+2 → accumulators updated at t+3 edge (visible from t+3).
- Full throughput: one beat per cycle while in_ready=1.
- in_ready is registered-state driven only; no combinational path from in_valid.
- start at cycle 0 → RUN from cycle 1; num_samples=0 → DRAIN cycle 2, REPORT/done cycle 3.
- done asserts the cycle after the last accumulator update is visible-ready; outputs stable when done=1.

## Configuration
- ERR_BIAS_EN defined: ed_bias accumulates signed (apx − exact) per sample, two's complement, cleared on start; reveals systematic under/over-estimation.
- Undefined: ed_bias tied to 0, no bias datapath synthesised; all other behaviour identical.

## Structure
- Package approx_err_pkg: state enum (IDLE, RUN, DRAIN, REPORT), width helper constants (N+1, N+1+CNT_W).
- Sub-module err_distance: two-stage pipeline (exact/apx register, ED + signed diff register) with valid bit; top holds FSM, counters and accumulators.

## Test plan
- num_samples=3, all exact results (x=1,y=1,s=2; x=0x00FF,y=0x00FF,s=0x01FE; x=0,y=0,s=0) → done once, sample_count=3, err_count=0, ed_max=0, ed_sum=0.
- num_samples=2: x=y=0xFFFF, {co,s}=0x1FFFF (ED 1); x=y=0xFFFF, {co,s}=0x0FFFE (ED 0x10000) → err_count=2, ed_max=0x10000, ed_sum=0x10001; with ERR_BIAS_EN ed_bias=−65535.
- in_valid held high continuously, num_samples=2 → exactly 2 transfers, in_ready=0 from third cycle, sample_count=2.
- num_samples=0 → done at cycle 3 after start, all results 0, in_ready never high.
- rst asserted mid-RUN after 1 sample → same cycle all outputs 0, busy=0; next start with num_samples=1 runs cleanly.
- start pulsed during RUN with different num_samples → ignored; run completes with originally latched count.
